// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared types and constants for the two-port 256Kx16 async SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_STROBE,
    HI_SETUP,
    HI_STROBE,
    DONE,
    TURN
  } sram_st_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } sram_ctl_t;

  localparam sram_ctl_t CTL_OFF = '1;

  // Returns {ub_n, lb_n} for one halfword; reads always enable both lanes.
  function automatic logic [1:0] lane_n(input logic we, input logic [3:0] bm, input logic hi);
    if (!we) return 2'b00;
    return hi ? ~bm[3:2] : ~bm[1:0];
  endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_if.sv
// Requester-side bus of the SRAM arbiter: two 32-bit ports plus shared read data.
interface sram_arbiter_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 19
);

  logic [1:0]                   i_req;
  logic [1:0]                   i_we;
  logic [1:0][ADDR_W-1:0]       i_addr;
  logic [1:0][WORD_W-1:0]       i_wdata;
  logic [1:0][3:0]              i_bmask;
  logic [1:0]                   o_ack;
  logic [WORD_W-1:0]            o_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_bmask,
    input  o_ack, o_rdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_bmask,
    output o_ack, o_rdata
  );

endinterface

// File: rtl/sram_arbiter_ctrl_arb.sv
// Two-requester grant logic. SRAM_ARB_RR_EN selects round-robin ties;
// otherwise port 1 (LSU) wins every tie.
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       gnt_id
);

  logic tie_id;

  assign valid  = |req;
  assign gnt_id = (&req) ? tie_id : req[1];

`ifdef SRAM_ARB_RR_EN
  logic last_q;

  // Reset value 1 makes port 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= 1'b1;
    else if (take) last_q <= gnt_id;
  end

  assign tie_id = ~last_q;
`else
  logic unused_rr;

  assign unused_rr = ^{clk, rst, take};
  assign tie_id    = 1'b1;
`endif

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Arbitrates two 32-bit requesters onto a 256Kx16 async SRAM, two halfword
// cycles per word. Tie policy lives in sram_rr_arbiter (SRAM_ARB_RR_EN).
module sram_arbiter_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = 19
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_arbiter_ctrl_if.slave bus,
  output logic               o_busy,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_ub_n,
  output logic               o_sram_lb_n,
  inout  logic [SRAM_DW-1:0] io_sram_dq
);

  localparam int CW   = $clog2(WAIT_CYC + 1);
  localparam int WA_W = ADDR_W - 2;
  localparam int LA_W = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);

  sram_st_e            state;
  sram_ctl_t           ctl;
  logic                gnt_q;
  logic                we_q;
  logic [WA_W-1:0]     word_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [3:0]          bmask_q;
  logic [CW-1:0]       cnt;
  logic [SRAM_DW-1:0]  lo_q;
  logic [SRAM_DW-1:0]  dq_out;
  logic                dq_oe;
  logic [SRAM_AW-1:0]  addr_q;
  logic [1:0]          ack_q;
  logic [WORD_W-1:0]   rdata_q;

  logic                arb_valid;
  logic                arb_id;
  logic                take;

  logic                cur_gnt;
  logic                cur_we;
  logic [WA_W-1:0]     cur_word;
  logic [WORD_W-1:0]   cur_wdata;
  logic [3:0]          cur_bmask;
  logic                setup_hi;
  logic [1:0]          lanes;
  sram_ctl_t           setup_ctl;
  logic [SRAM_AW-1:0]  setup_addr;
  logic [SRAM_DW-1:0]  setup_dq;
  logic [1:0]          ack_vec;
  logic                hi_skip;
  logic                unused_lsb;

  assign take = (state == IDLE) && arb_valid;

  sram_rr_arbiter u_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    (bus.i_req),
    .take   (take),
    .valid  (arb_valid),
    .gnt_id (arb_id)
  );

  // In IDLE the next setup is built from the granted port's live inputs, so
  // the first SRAM cycle starts without waiting for the latch.
  always_comb begin
    if (state == IDLE) begin
      cur_gnt   = arb_id;
      cur_we    = bus.i_we[arb_id];
      cur_word  = bus.i_addr[arb_id][ADDR_W-1:2];
      cur_wdata = bus.i_wdata[arb_id];
      cur_bmask = bus.i_bmask[arb_id];
      setup_hi  = cur_we && (cur_bmask[1:0] == 2'b00);
    end else begin
      cur_gnt   = gnt_q;
      cur_we    = we_q;
      cur_word  = word_q;
      cur_wdata = wdata_q;
      cur_bmask = bmask_q;
      setup_hi  = 1'b1;
    end
    lanes      = lane_n(cur_we, cur_bmask, setup_hi);
    setup_ctl  = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, ub_n: lanes[1], lb_n: lanes[0]};
    setup_addr = {LA_W'(cur_word), setup_hi};
    setup_dq   = setup_hi ? cur_wdata[31:16] : cur_wdata[15:0];
    ack_vec    = {cur_gnt, ~cur_gnt};
  end

  assign hi_skip = we_q && (bmask_q[3:2] == 2'b00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ctl     <= CTL_OFF;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      cnt     <= '0;
      lo_q    <= '0;
      dq_out  <= '0;
      dq_oe   <= 1'b0;
      addr_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_q   <= cur_gnt;
            we_q    <= cur_we;
            word_q  <= cur_word;
            wdata_q <= cur_wdata;
            bmask_q <= cur_bmask;
            if (cur_we && (cur_bmask == 4'b0000)) begin
              state <= DONE;
              ack_q <= ack_vec;
            end else begin
              state  <= setup_hi ? HI_SETUP : LO_SETUP;
              ctl    <= setup_ctl;
              addr_q <= setup_addr;
              dq_oe  <= cur_we;
              dq_out <= setup_dq;
            end
          end
        end
        LO_SETUP, HI_SETUP: begin
          state <= (state == LO_SETUP) ? LO_STROBE : HI_STROBE;
          cnt   <= '0;
          if (we_q) begin
            ctl.we_n <= 1'b0;
          end else begin
            ctl.oe_n <= 1'b0;
            ctl.ub_n <= 1'b0;
            ctl.lb_n <= 1'b0;
          end
        end
        LO_STROBE, HI_STROBE: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            if (state == LO_STROBE) lo_q <= io_sram_dq;
            if (!we_q && (state == HI_STROBE)) rdata_q <= {io_sram_dq, lo_q};
            if ((state == LO_STROBE) && !hi_skip) begin
              state  <= HI_SETUP;
              ctl    <= setup_ctl;
              addr_q <= setup_addr;
              dq_oe  <= we_q;
              dq_out <= setup_dq;
            end else begin
              state <= DONE;
              ctl   <= CTL_OFF;
              dq_oe <= 1'b0;
              ack_q <= ack_vec;
            end
          end
        end
        DONE:    state <= TURN;
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io_sram_dq  = dq_oe ? dq_out : 'z;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ctl.ce_n;
  assign o_sram_oe_n = ctl.oe_n;
  assign o_sram_we_n = ctl.we_n;
  assign o_sram_ub_n = ctl.ub_n;
  assign o_sram_lb_n = ctl.lb_n;
  assign o_busy      = (state != IDLE);
  assign bus.o_ack   = ack_q;
  assign bus.o_rdata = rdata_q;

  assign unused_lsb = ^{bus.i_addr[0][1:0], bus.i_addr[1][1:0]};

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_arbiter_ctrl;
  import sram_ctrl_pkg::*;

  localparam int ADDR_W   = 19;
  localparam int WAIT_CYC = 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        busy;
  logic [17:0] sa;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  wire  [15:0] dq;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  sram_arbiter_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  sram_arbiter_ctrl #(.WAIT_CYC(WAIT_CYC), .ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_busy      (busy),
    .o_sram_addr (sa),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_we_n (we_n),
    .o_sram_ub_n (ub_n),
    .o_sram_lb_n (lb_n),
    .io_sram_dq  (dq)
  );

  // SRAM model: 256 halfwords, address bits above 7 ignored.
  logic [15:0] mem [256];
  int          we_low_cnt = 0;
  int          ack_cnt [2];
  int          ack_log [$];

  assign dq = (!ce_n && !oe_n && we_n) ? mem[sa[7:0]] : 16'hzzzz;

  always @(posedge i_clk) begin
    if (!ce_n && !we_n) begin
      we_low_cnt++;
      if (!lb_n) mem[sa[7:0]][7:0]  <= dq[7:0];
      if (!ub_n) mem[sa[7:0]][15:8] <= dq[15:8];
    end
  end

  always @(negedge i_clk) begin
    if (bus.o_ack[0]) begin ack_cnt[0]++; ack_log.push_back(0); end
    if (bus.o_ack[1]) begin ack_cnt[1]++; ack_log.push_back(1); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (busy && n < 20) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  // One transaction on port p; lat = negedges from request to ack (-1 on timeout).
  task automatic txn(input int p, input logic we, input logic [18:0] addr,
                     input logic [31:0] wd, input logic [3:0] bm, input bit drop_early,
                     output int lat, output logic [1:0] ackv);
    wait_idle();
    bus.i_we[p]    = we;
    bus.i_addr[p]  = addr;
    bus.i_wdata[p] = wd;
    bus.i_bmask[p] = bm;
    bus.i_req[p]   = 1'b1;
    lat  = -1;
    ackv = 2'b00;
    for (int n = 1; n <= 30; n++) begin
      @(negedge i_clk);
      if (drop_early && n == 1) bus.i_req[p] = 1'b0;
      if (bus.o_ack != 2'b00) begin
        lat  = n;
        ackv = bus.o_ack;
        break;
      end
    end
    bus.i_req[p] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    int         c0;
    int         wl0;
    logic [1:0] ackv;
    int         exp_gnt [4];

    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_bmask = '0;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check("rst_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
    check("rst_addr",    {14'b0, sa}, 32'h0);
    check("rst_ack",     {30'b0, bus.o_ack}, 32'h0);
    check("rst_rdata",   bus.o_rdata, 32'h0);
    check("rst_busy",    {31'b0, busy}, 32'h0);
    i_rst = 1'b0;

    // Port 0 read, word 2 -> halfwords 4/5
    mem[4] = 16'hBEEF;
    mem[5] = 16'hCAFE;
    txn(0, 1'b0, 19'h00008, 32'h0, 4'hF, 1'b0, lat, ackv);
    check("rd_lat",   lat, 5);
    check("rd_ack",   {30'b0, ackv}, 32'h1);
    check("rd_data",  bus.o_rdata, 32'hCAFEBEEF);

    // Port 1 write, mask 0110 -> UB of lo, LB of hi
    mem[8] = 16'hAAAA;
    mem[9] = 16'h5555;
    txn(1, 1'b1, 19'h00010, 32'h11223344, 4'b0110, 1'b0, lat, ackv);
    check("wr_lat",   lat, 5);
    check("wr_ack",   {30'b0, ackv}, 32'h2);
    check("wr_lo",    {16'b0, mem[8]}, 32'h33AA);
    check("wr_hi",    {16'b0, mem[9]}, 32'h5522);
    check("wr_rdata_held", bus.o_rdata, 32'hCAFEBEEF);

    // Write touching only the hi half: lo cycles skipped
    mem[12] = 16'h1234;
    mem[13] = 16'h5678;
    txn(0, 1'b1, 19'h00018, 32'hA1B2C3D4, 4'b1100, 1'b0, lat, ackv);
    check("hionly_lat", lat, 3);
    check("hionly_lo",  {16'b0, mem[12]}, 32'h1234);
    check("hionly_hi",  {16'b0, mem[13]}, 32'hA1B2);

    // Write with empty mask: straight to DONE, no strobe
    mem[16] = 16'h0F0F;
    mem[17] = 16'hF0F0;
    wl0 = we_low_cnt;
    txn(1, 1'b1, 19'h00020, 32'hFFFFFFFF, 4'b0000, 1'b0, lat, ackv);
    check("nomask_lat",  lat, 1);
    check("nomask_ack",  {30'b0, ackv}, 32'h2);
    check("nomask_wen",  we_low_cnt - wl0, 0);
    check("nomask_m16",  {16'b0, mem[16]}, 32'h0F0F);
    check("nomask_m17",  {16'b0, mem[17]}, 32'hF0F0);

    // Top of address space, low address bits set
    mem[254] = 16'h1111;
    mem[255] = 16'h2222;
    txn(1, 1'b0, 19'h7FFFF, 32'h0, 4'h0, 1'b0, lat, ackv);
    check("top_lat",  lat, 5);
    check("top_data", bus.o_rdata, 32'h22221111);

    // Requester drops i_req right after the grant
    mem[20] = 16'h0102;
    mem[21] = 16'h0304;
    c0 = ack_cnt[0];
    txn(0, 1'b0, 19'h00028, 32'h0, 4'h0, 1'b1, lat, ackv);
    repeat (6) @(negedge i_clk);
    check("drop_lat",  lat, 5);
    check("drop_acks", ack_cnt[0] - c0, 1);
    check("drop_data", bus.o_rdata, 32'h03040102);

    // Reset during LO_STROBE of a write
    mem[24] = 16'h7777;
    wait_idle();
    bus.i_we[0]    = 1'b1;
    bus.i_addr[0]  = 19'h00030;
    bus.i_wdata[0] = 32'h99999999;
    bus.i_bmask[0] = 4'hF;
    bus.i_req[0]   = 1'b1;
    repeat (2) @(negedge i_clk);
    check("mid_strobe_wen", {31'b0, we_n}, 32'h0);
    c0 = ack_cnt[0];
    i_rst = 1'b1;
    #1;
    check("arst_strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
    check("arst_busy",    {31'b0, busy}, 32'h0);
    check("arst_addr",    {14'b0, sa}, 32'h0);
    @(negedge i_clk);
    bus.i_req[0] = 1'b0;
    i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    check("arst_noack", ack_cnt[0] - c0, 0);
    check("arst_mem",   {16'b0, mem[24]}, 32'h7777);

    // Both ports requesting continuously
`ifdef SRAM_ARB_RR_EN
    exp_gnt = '{0, 1, 0, 1};
`else
    exp_gnt = '{1, 1, 1, 1};
`endif
    ack_log.delete();
    bus.i_we     = 2'b00;
    bus.i_addr   = {19'h00004, 19'h00000};
    bus.i_req    = 2'b11;
    for (int n = 0; n < 200 && ack_log.size() < 4; n++) @(negedge i_clk);
    bus.i_req = 2'b00;
    repeat (10) @(negedge i_clk);
    check("tie_count", (ack_log.size() >= 4) ? 32'd4 : ack_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log.size()) check($sformatf("tie_gnt%0d", i), ack_log[i], exp_gnt[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
